// File: rtl/tick_sequencer_if.sv
// Configuration handshake between control logic and the tick sequencer.
// The master issues commands and the sequencer (slave) reports readiness.
interface tick_sequencer_if #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_mode, cfg_half, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_half, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/tick_sequencer.sv
// Square-wave divider with idle / continuous / fixed-length burst sequencing,
// reconfigured through a valid/ready command port.
module tick_sequencer #(
  parameter int CNT_W        = 32,
  parameter int BURST_W      = 8,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  tick_sequencer_if.slave  cfg,
  output logic             fout,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;
  localparam logic [1:0] M_RSVD  = 2'b11;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, half, half_n;
  logic [BURST_W-1:0] rem, rem_n;
  logic               fout_n, done_n;
  logic               accept, wrap;

  assign cfg.cfg_ready = rst && (state != BURST);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign wrap          = (cnt == half - CNT_W'(1));
  assign busy          = (state == RUN) || (state == BURST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      half  <= CNT_W'(DEFAULT_HALF);
      rem   <= '0;
      fout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      half  <= half_n;
      rem   <= rem_n;
      fout  <= fout_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    half_n  = half;
    rem_n   = rem;
    fout_n  = fout;
    done_n  = 1'b0;
    // A reserved-mode accept falls through so counting continues untouched.
    if (accept && (cfg.cfg_mode != M_RSVD)) begin
      half_n = (cfg.cfg_half == '0) ? CNT_W'(1) : cfg.cfg_half;
      cnt_n  = '0;
      fout_n = 1'b0;
      unique case (cfg.cfg_mode)
        M_RUN:   state_n = RUN;
        M_BURST: begin
          if (cfg.cfg_count != '0) begin
            state_n = BURST;
            rem_n   = cfg.cfg_count;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        M_STOP:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (wrap) begin
        cnt_n  = '0;
        fout_n = ~fout;
        // A period ends on the falling toggle; the last one closes the burst.
        if ((state == BURST) && fout) begin
          rem_n = rem - BURST_W'(1);
          if (rem == BURST_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: expected {fout,busy,done,cfg_ready}
// per cycle are queued as stimulus is driven and checked after each edge.
module tb_tick_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic fout, busy, done;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];

  tick_sequencer_if #(.CNT_W(32), .BURST_W(8)) bus ();

  tick_sequencer #(.CNT_W(32), .BURST_W(8), .DEFAULT_HALF(25000000)) dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (bus),
    .fout (fout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic ph(input int j, input int h);
    return ((j / h) % 2) == 1;
  endfunction

  task automatic push(input logic [3:0] v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [3:0] obs;
    @(posedge clk);
    #1;
    obs = {fout, busy, done, bus.cfg_ready};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b (fout,busy,done,ready)", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] h, input logic [7:0] c,
                      input logic [3:0] v, input string tag);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = m;
    bus.cfg_half  = h;
    bus.cfg_count = c;
    push(v, tag);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = 2'b00;
    bus.cfg_half  = '0;
    bus.cfg_count = '0;

    // reset, then idle
    for (int j = 0; j < 3; j++) begin push(4'b0000, "reset"); tick(); end
    rst = 1'b1;
    for (int j = 0; j < 20; j++) begin push(4'b0001, "idle"); tick(); end

    // continuous, half 4, then reload to half 2 while fout is high, then stop
    send(2'b01, 32'd4, 8'd0, 4'b0101, "run_acc");
    for (int j = 1; j <= 85; j++) begin push({ph(j, 4), 3'b101}, "run_h4"); tick(); end
    send(2'b01, 32'd2, 8'd0, 4'b0101, "reload");
    for (int j = 1; j <= 14; j++) begin push({ph(j, 2), 3'b101}, "run_h2"); tick(); end
    send(2'b00, 32'd9, 8'd0, 4'b0001, "stop");
    for (int j = 0; j < 5; j++) begin push(4'b0001, "stop_idle"); tick(); end

    // reserved mode in idle and in run
    send(2'b11, 32'd7, 8'd9, 4'b0001, "rsvd_idle");
    for (int j = 0; j < 3; j++) begin push(4'b0001, "rsvd_idle_after"); tick(); end
    send(2'b01, 32'd3, 8'd0, 4'b0101, "run3_acc");
    for (int j = 1; j <= 4; j++) begin push({ph(j, 3), 3'b101}, "run_h3"); tick(); end
    send(2'b11, 32'd1, 8'd1, {ph(5, 3), 3'b101}, "rsvd_run");
    for (int j = 6; j <= 12; j++) begin push({ph(j, 3), 3'b101}, "rsvd_run_after"); tick(); end
    send(2'b00, 32'd1, 8'd0, 4'b0001, "stop2");

    // burst half 3 count 2; a run command is held valid from mid-burst
    send(2'b10, 32'd3, 8'd2, 4'b0100, "burst_acc");
    for (int j = 1; j <= 12; j++) begin
      if (j < 12) push({ph(j, 3), 3'b100}, "burst");
      else        push(4'b0011, "burst_done");
      tick();
      if (j == 5) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = 2'b01;
        bus.cfg_half  = 32'd2;
        bus.cfg_count = 8'd0;
      end
    end
    push(4'b0101, "held_acc");
    tick();
    bus.cfg_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin push({ph(j, 2), 3'b101}, "held_run"); tick(); end
    send(2'b00, 32'd1, 8'd0, 4'b0001, "stop3");

    // burst with count 0
    send(2'b10, 32'd5, 8'd0, 4'b0011, "burst0");
    for (int j = 0; j < 3; j++) begin push(4'b0001, "burst0_after"); tick(); end

    // half 0 behaves as half 1
    send(2'b01, 32'd0, 8'd0, 4'b0101, "half0_acc");
    for (int j = 1; j <= 8; j++) begin push({ph(j, 1), 3'b101}, "half0"); tick(); end
    send(2'b00, 32'd1, 8'd0, 4'b0001, "stop4");

    // reset mid-burst, then a fresh burst of one period
    send(2'b10, 32'd2, 8'd5, 4'b0100, "rburst_acc");
    for (int j = 1; j <= 6; j++) begin push({ph(j, 2), 3'b100}, "rburst"); tick(); end
    rst = 1'b0;
    push(4'b0000, "rst_mid");
    tick();
    rst = 1'b1;
    for (int j = 0; j < 25; j++) begin push(4'b0001, "rst_after"); tick(); end
    send(2'b10, 32'd1, 8'd1, 4'b0100, "fresh_acc");
    push(4'b1100, "fresh_rise");
    tick();
    push(4'b0011, "fresh_done");
    tick();
    push(4'b0001, "fresh_idle");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_sequencer.md
# tick_sequencer

Programmable controller for the design's square-wave divider: owns the half-period counter and `fout`, and sequences it through idle, continuous and fixed-length burst operation under a valid/ready configuration handshake. It sits between control logic (FSM or register block) and any LED, buzzer or strobe consumer of `fout`. After reset, `fout` is held low until a start command is accepted. `DEFAULT_HALF` is the half-period loaded at reset, so a start with `cfg_half = DEFAULT_HALF` reproduces the legacy 25,000,000-cycle toggle.

## Interface
- `CNT_W`, 32, width of the half-period counter and `cfg_half`.
- `BURST_W`, 8, width of the burst length field.
- `DEFAULT_HALF`, 25000000, half-period loaded at reset (clock cycles).
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `cfg_valid` input 1: configuration command present.
- `cfg_ready` output 1: block can accept a command.
- `cfg_mode` input 2: 00 stop, 01 continuous, 10 burst, 11 reserved.
- `cfg_half` input CNT_W: half-period in cycles; 0 is treated as 1.
- `cfg_count` input BURST_W: number of full periods in a burst.
- `fout` output 1: divided square wave (registered).
- `busy` output 1: high in RUN or BURST.
- `done` output 1: one-cycle pulse when a burst completes.

## Operation
- States:
  - IDLE: `fout` = 0, counter held at 0.
  - RUN: free-running toggle.
  - BURST: toggle, counting down the remaining periods.
- Accept rule: a transfer occurs on an edge where `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = 1 in IDLE and RUN; 0 in BURST; 0 while `rst` is low.
  - `cfg_mode`, `cfg_half` and `cfg_count` are sampled only on an accepted transfer.
- On any accept with mode ≠ 11:
  - half register ← max(`cfg_half`, 1).
  - counter ← 0.
  - `fout` ← 0.
- Mode handling on accept:
  - 00: go to IDLE (stops RUN immediately).
  - 01: go to RUN; issuing 01 while in RUN reloads the half-period and restarts the phase.
  - 10 with `cfg_count` > 0: go to BURST with remaining ← `cfg_count`.
  - 10 with `cfg_count` = 0: go to IDLE and pulse `done` in the next cycle.
  - 11: accepted and ignored (no state, register or output change).
- Counting in RUN and BURST, each edge:
  - If counter == half−1: toggle `fout` and clear the counter.
  - Otherwise: increment the counter.
- BURST completion:
  - Each 1→0 toggle decrements remaining.
  - The toggle that takes remaining to 0 also sets state ← IDLE and `done` ← 1 on the same edge.
- `done` is low in every other cycle. `busy` = (state == RUN || state == BURST).
- Counter width is CNT_W; the compare is against the half register, so the counter never wraps.

## Timing
- Reset values (first edge with `rst` = 0):
  - `fout` = 0, `done` = 0, `busy` = 0, state IDLE.
  - counter = 0, half register = `DEFAULT_HALF`, remaining = 0.
- Reset mid-RUN or mid-BURST: abandoned on that edge; no `done` pulse.
- Start latency: command accepted at edge k with half H.
  - First rise at edge k+H.
  - Fall at k+2H.
  - Period 2H cycles, 50% duty.
- H = 1: `fout` toggles every edge (period 2).
- Burst of N periods accepted at edge k:
  - Rises at k+H(2i+1) and falls at k+2H(i+1), for i = 0..N−1.
  - `done` = 1, `busy` = 0 and `cfg_ready` = 1 in the cycle after edge k+2NH.
  - A new command may be accepted at edge k+2NH+1.
- `cfg_valid` held while `cfg_ready` = 0: no effect; the command is accepted on the first edge where `cfg_ready` = 1.

## Test plan
- Reset then idle. Stimulus: `rst` low for 3 cycles, then high for 20 cycles. Required: `fout` = 0, `busy` = 0, `done` = 0, `cfg_ready` = 1 throughout.
- Continuous start. Stimulus: mode 01, half = 4, accepted at edge k. Required: `fout` rises at k+4 and falls at k+8; period 8, stable over 10 periods; `busy` = 1.
- Burst. Stimulus: mode 10, half = 3, count = 2, accepted at edge k. Required: rises at k+3 and k+9, falls at k+6 and k+12; `done` is a single cycle after k+12; `cfg_ready` is 0 from k+1 through k+12.
- Zero and degenerate values:
  - Burst with count = 0: `done` pulse one cycle after accept, `fout` stays 0.
  - Continuous with half = 0: behaves as half = 1, toggling every cycle.
- Reconfiguration:
  - In RUN half = 4, issue mode 01 half = 2: `fout` ← 0 and the new period of 4 starts immediately.
  - Then issue mode 00: `fout` = 0, `busy` = 0 after the accept edge.
  - Mode 11: no change.
- Reset mid-burst. Stimulus: burst with half = 2, count = 5; `rst` low on the 7th cycle. Required: all outputs at reset values after that edge, no `done` pulse, and a fresh command is accepted normally afterwards.
